// File: rtl/mips_defs.sv
// Shared MIPS-subset definitions: opcodes, funct codes, FSM states, decoded
// instruction classes, datapath select codes and the control-word payload.
package mips_defs;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_REG  = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [ALU_W-1:0] ALU_NOP = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_LUI = 3'b100;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_IF  = 3'd0,
        S_DCD = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_ILL, CL_ADDU, CL_SUBU, CL_ORI, CL_LUI,
        CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR
    } cls_t;

    typedef struct packed {
        logic             pc_wr;
        logic             ir_wr;
        logic [1:0]       npc_op;
        logic [1:0]       ext_op;
        logic             alu_src;
        logic [ALU_W-1:0] alu_op;
        logic [1:0]       reg_dst;
        logic [1:0]       mem_to_reg;
        logic             reg_wr;
        logic             dm_wr;
    } ctrl_t;

    // Operand/ALU fields for a class; held constant from EXE through WB.
    function automatic ctrl_t exe_fields(input cls_t cls);
        ctrl_t c;
        c = '0;
        case (cls)
            CL_ADDU: c.alu_op = ALU_ADD;
            CL_SUBU: c.alu_op = ALU_SUB;
            CL_ORI:  begin c.alu_op = ALU_OR;  c.alu_src = 1'b1; c.ext_op = EXT_ZERO; end
            CL_LUI:  begin c.alu_op = ALU_LUI; c.alu_src = 1'b1; c.ext_op = EXT_LUI;  end
            CL_LW,
            CL_SW:   begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.ext_op = EXT_SIGN; end
            CL_BEQ:  begin c.alu_op = ALU_SUB; c.ext_op = EXT_SIGN; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational op/funct to instruction-class decoder.
//   i_op    : opcode field of IR
//   i_funct : funct field of IR (R-type only)
//   o_cls_c : decoded class, CL_ILL for anything unsupported
module ctrl_decode
    import mips_defs::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output cls_t       o_cls_c
);

    always_comb begin
        o_cls_c = CL_ILL;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_cls_c = CL_ADDU;
                    FN_SUBU: o_cls_c = CL_SUBU;
                    FN_JR:   o_cls_c = CL_JR;
                    default: o_cls_c = CL_ILL;
                endcase
            end
            OP_J:    o_cls_c = CL_J;
            OP_JAL:  o_cls_c = CL_JAL;
            OP_BEQ:  o_cls_c = CL_BEQ;
            OP_ORI:  o_cls_c = CL_ORI;
            OP_LUI:  o_cls_c = CL_LUI;
            OP_LW:   o_cls_c = CL_LW;
            OP_SW:   o_cls_c = CL_SW;
            default: o_cls_c = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mcyc_ctrl.sv
// Multi-cycle MIPS control FSM (IF, DCD, EXE, MEM, WB).
//   clk, rst_n          : clock, async active-low reset
//   op, funct, zero     : IR fields and ALU equality flag
//   dm_rdy              : data-memory ready, looked at only in MEM
//   pc_wr..dm_wr        : datapath controls
//   state_o             : current state
// Outputs decode the state register (plus the class latched in DCD) and are
// forced low while rst_n is low, so a reset mid-access kills any write at once
// and the first edge after release performs a fetch.
module mcyc_ctrl
    import mips_defs::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       dm_rdy,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic [1:0] npc_op,
    output logic [1:0] ext_op,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_wr,
    output logic       dm_wr,
    output logic [2:0] state_o
);

    state_t r_state;
    state_t w_state_nxt;
    cls_t   r_cls;
    cls_t   w_cls;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

    ctrl_decode u_decode (
        .i_op    (op),
        .i_funct (funct),
        .o_cls_c (w_cls)
    );

    // State register; class captured at the end of DCD for EXE/MEM/WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IF;
            r_cls   <= CL_ILL;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DCD) begin
                r_cls <= w_cls;
            end
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '0;
        case (r_state)
            S_IF: begin
                w_ctrl.ir_wr  = 1'b1;
                w_ctrl.pc_wr  = 1'b1;
                w_ctrl.npc_op = NPC_PC4;
                w_state_nxt   = S_DCD;
            end
            S_DCD: begin
                // Jumps retire here using the live decode of the fresh IR.
                case (w_cls)
                    CL_J: begin
                        w_ctrl.pc_wr  = 1'b1;
                        w_ctrl.npc_op = NPC_JMP;
                        w_state_nxt   = S_IF;
                    end
                    CL_JAL: begin
                        w_ctrl.pc_wr      = 1'b1;
                        w_ctrl.npc_op     = NPC_JMP;
                        w_ctrl.reg_wr     = 1'b1;
                        w_ctrl.reg_dst    = RDST_R31;
                        w_ctrl.mem_to_reg = M2R_PC4;
                        w_state_nxt       = S_IF;
                    end
                    CL_JR: begin
                        w_ctrl.pc_wr  = 1'b1;
                        w_ctrl.npc_op = NPC_REG;
                        w_state_nxt   = S_IF;
                    end
                    CL_ILL:  w_state_nxt = S_IF;
                    default: w_state_nxt = S_EXE;
                endcase
            end
            S_EXE: begin
                w_ctrl = exe_fields(r_cls);
                case (r_cls)
                    CL_BEQ: begin
                        w_ctrl.pc_wr  = zero;
                        w_ctrl.npc_op = NPC_BR;
                        w_state_nxt   = S_IF;
                    end
                    CL_LW, CL_SW:                      w_state_nxt = S_MEM;
                    CL_ADDU, CL_SUBU, CL_ORI, CL_LUI:  w_state_nxt = S_WB;
                    default:                           w_state_nxt = S_IF;
                endcase
            end
            S_MEM: begin
                w_ctrl       = exe_fields(r_cls);
                w_ctrl.dm_wr = (r_cls == CL_SW);
                if (!MEM_WAIT_EN || dm_rdy) begin
                    w_state_nxt = (r_cls == CL_LW) ? S_WB : S_IF;
                end
            end
            S_WB: begin
                w_ctrl            = exe_fields(r_cls);
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.reg_dst    = (r_cls == CL_ADDU || r_cls == CL_SUBU) ? RDST_RD : RDST_RT;
                w_ctrl.mem_to_reg = (r_cls == CL_LW) ? M2R_MEM : M2R_ALU;
                w_state_nxt       = S_IF;
            end
            default: w_state_nxt = S_IF;
        endcase
    end

    assign w_out      = rst_n ? w_ctrl : '0;
    assign pc_wr      = w_out.pc_wr;
    assign ir_wr      = w_out.ir_wr;
    assign npc_op     = w_out.npc_op;
    assign ext_op     = w_out.ext_op;
    assign alu_src    = w_out.alu_src;
    assign alu_op     = w_out.alu_op;
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign reg_wr     = w_out.reg_wr;
    assign dm_wr      = w_out.dm_wr;
    assign state_o    = r_state;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Directed bench for mcyc_ctrl: instance a uses the default waiting MEM,
// instance b has MEM_WAIT_EN=0 and is held in reset until its own segment.
module tb_mcyc_ctrl;
    import mips_defs::*;

    logic       clk = 1'b0;
    logic       rst_n, rst_b;
    logic [5:0] op, funct, op_b, funct_b;
    logic       zero, dm_rdy, zero_b, dm_rdy_b;

    logic       pc_wr_a, ir_wr_a, alu_src_a, reg_wr_a, dm_wr_a;
    logic [1:0] npc_op_a, ext_op_a, reg_dst_a, m2r_a;
    logic [2:0] alu_op_a, state_a;
    logic       pc_wr_b, ir_wr_b, alu_src_b, reg_wr_b, dm_wr_b;
    logic [1:0] npc_op_b, ext_op_b, reg_dst_b, m2r_b;
    logic [2:0] alu_op_b, state_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mcyc_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .dm_rdy(dm_rdy),
        .pc_wr(pc_wr_a), .ir_wr(ir_wr_a), .npc_op(npc_op_a), .ext_op(ext_op_a),
        .alu_src(alu_src_a), .alu_op(alu_op_a), .reg_dst(reg_dst_a), .mem_to_reg(m2r_a),
        .reg_wr(reg_wr_a), .dm_wr(dm_wr_a), .state_o(state_a)
    );

    mcyc_ctrl #(.MEM_WAIT_EN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_b), .op(op_b), .funct(funct_b), .zero(zero_b), .dm_rdy(dm_rdy_b),
        .pc_wr(pc_wr_b), .ir_wr(ir_wr_b), .npc_op(npc_op_b), .ext_op(ext_op_b),
        .alu_src(alu_src_b), .alu_op(alu_op_b), .reg_dst(reg_dst_b), .mem_to_reg(m2r_b),
        .reg_wr(reg_wr_b), .dm_wr(dm_wr_b), .state_o(state_b)
    );

    wire [18:0] w_vec_a = {state_a, pc_wr_a, ir_wr_a, npc_op_a, ext_op_a, alu_src_a,
                           alu_op_a, reg_dst_a, m2r_a, reg_wr_a, dm_wr_a};
    wire [18:0] w_vec_b = {state_b, pc_wr_b, ir_wr_b, npc_op_b, ext_op_b, alu_src_b,
                           alu_op_b, reg_dst_b, m2r_b, reg_wr_b, dm_wr_b};

    // Expected vector: {state, pc_wr, ir_wr, npc, ext, alu_src, alu_op, reg_dst, m2r, reg_wr, dm_wr}
    function automatic logic [18:0] v(input logic [2:0] st, input logic pc, input logic ir,
                                      input logic [1:0] npc, input logic [1:0] ext,
                                      input logic src, input logic [2:0] alu,
                                      input logic [1:0] rdst, input logic [1:0] m2r,
                                      input logic rw, input logic dw);
        return {st, pc, ir, npc, ext, src, alu, rdst, m2r, rw, dw};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check instance a this cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [18:0] exp);
        check(tag, w_vec_a, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input string tag, input logic [18:0] exp);
        check(tag, w_vec_b, exp);
        @(posedge clk);
        #1;
    endtask

    logic [18:0] v_if, v_dcd0, v_lw_mem, v_sw_mem;

    initial begin
        v_if     = v(S_IF,  1, 1, NPC_PC4, 2'b00, 0, ALU_NOP, 2'b00, 2'b00, 0, 0);
        v_dcd0   = v(S_DCD, 0, 0, 2'b00,   2'b00, 0, ALU_NOP, 2'b00, 2'b00, 0, 0);
        v_lw_mem = v(S_MEM, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, 2'b00, 2'b00, 0, 0);
        v_sw_mem = v(S_MEM, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, 2'b00, 2'b00, 0, 1);

        rst_n = 1'b0; rst_b = 1'b0;
        op = 6'd0; funct = 6'd0; zero = 1'b0; dm_rdy = 1'b1;
        op_b = OP_SW; funct_b = 6'd0; zero_b = 1'b0; dm_rdy_b = 1'b0;

        #1;
        check("reset_a", w_vec_a, 19'd0);
        check("reset_b", w_vec_b, 19'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", w_vec_a, 19'd0);

        // addu: IF, DCD, EXE, WB
        @(negedge clk);
        rst_n = 1'b1; op = OP_RTYPE; funct = FN_ADDU;
        #1;
        cyc("addu_if",  v_if);
        cyc("addu_dcd", v_dcd0);
        cyc("addu_exe", v(S_EXE, 0, 0, 2'b00, EXT_ZERO, 0, ALU_ADD, 2'b00, 2'b00, 0, 0));
        cyc("addu_wb",  v(S_WB,  0, 0, 2'b00, EXT_ZERO, 0, ALU_ADD, RDST_RD, M2R_ALU, 1, 0));

        // lui
        op = OP_LUI;
        cyc("lui_if",  v_if);
        cyc("lui_dcd", v_dcd0);
        cyc("lui_exe", v(S_EXE, 0, 0, 2'b00, EXT_LUI, 1, ALU_LUI, 2'b00, 2'b00, 0, 0));
        cyc("lui_wb",  v(S_WB,  0, 0, 2'b00, EXT_LUI, 1, ALU_LUI, RDST_RT, M2R_ALU, 1, 0));

        // ori
        op = OP_ORI;
        cyc("ori_if",  v_if);
        cyc("ori_dcd", v_dcd0);
        cyc("ori_exe", v(S_EXE, 0, 0, 2'b00, EXT_ZERO, 1, ALU_OR, 2'b00, 2'b00, 0, 0));
        cyc("ori_wb",  v(S_WB,  0, 0, 2'b00, EXT_ZERO, 1, ALU_OR, RDST_RT, M2R_ALU, 1, 0));

        // beq taken / not taken
        op = OP_BEQ; zero = 1'b1;
        cyc("beq1_if",  v_if);
        cyc("beq1_dcd", v_dcd0);
        cyc("beq1_exe", v(S_EXE, 1, 0, NPC_BR, EXT_SIGN, 0, ALU_SUB, 2'b00, 2'b00, 0, 0));
        zero = 1'b0;
        cyc("beq0_if",  v_if);
        cyc("beq0_dcd", v_dcd0);
        cyc("beq0_exe", v(S_EXE, 0, 0, NPC_BR, EXT_SIGN, 0, ALU_SUB, 2'b00, 2'b00, 0, 0));

        // jal, jr, j
        op = OP_JAL;
        cyc("jal_if",  v_if);
        cyc("jal_dcd", v(S_DCD, 1, 0, NPC_JMP, 2'b00, 0, ALU_NOP, RDST_R31, M2R_PC4, 1, 0));
        op = OP_RTYPE; funct = FN_JR;
        cyc("jr_if",   v_if);
        cyc("jr_dcd",  v(S_DCD, 1, 0, NPC_REG, 2'b00, 0, ALU_NOP, 2'b00, 2'b00, 0, 0));
        op = OP_J;
        cyc("j_if",    v_if);
        cyc("j_dcd",   v(S_DCD, 1, 0, NPC_JMP, 2'b00, 0, ALU_NOP, 2'b00, 2'b00, 0, 0));

        // illegal opcode: DCD with no writes, straight back to IF
        op = 6'b111111;
        cyc("ill_if",  v_if);
        cyc("ill_dcd", v_dcd0);

        // sw with dm_rdy low for three MEM cycles
        op = OP_SW; dm_rdy = 1'b0;
        cyc("sw_if",   v_if);
        cyc("sw_dcd",  v_dcd0);
        cyc("sw_exe",  v(S_EXE, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, 2'b00, 2'b00, 0, 0));
        cyc("sw_mem1", v_sw_mem);
        cyc("sw_mem2", v_sw_mem);
        cyc("sw_mem3", v_sw_mem);
        check("sw_mem4", w_vec_a, v_sw_mem);
        dm_rdy = 1'b1;
        @(posedge clk);
        #1;

        // lw stalled in MEM, then reset pulse
        op = OP_LW; dm_rdy = 1'b0;
        cyc("lw_if",   v_if);
        cyc("lw_dcd",  v_dcd0);
        cyc("lw_exe",  v(S_EXE, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, 2'b00, 2'b00, 0, 0));
        cyc("lw_mem1", v_lw_mem);
        check("lw_mem2", w_vec_a, v_lw_mem);
        #2;
        rst_n = 1'b0;
        #1;
        check("lw_rst_async", w_vec_a, 19'd0);
        @(negedge clk);
        rst_n = 1'b1; dm_rdy = 1'b1;
        #1;
        cyc("rst_fetch", v_if);

        // full lw with memory ready
        cyc("lw2_dcd", v_dcd0);
        cyc("lw2_exe", v(S_EXE, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, 2'b00, 2'b00, 0, 0));
        cyc("lw2_mem", v_lw_mem);
        cyc("lw2_wb",  v(S_WB, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, RDST_RT, M2R_MEM, 1, 0));
        check("lw2_done", w_vec_a, v_if);

        // Instance b: sw with dm_rdy low still spends exactly one cycle in MEM
        op = OP_RTYPE; funct = FN_ADDU;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        cyc_b("nw_if",  v_if);
        cyc_b("nw_dcd", v_dcd0);
        cyc_b("nw_exe", v(S_EXE, 0, 0, 2'b00, EXT_SIGN, 1, ALU_ADD, 2'b00, 2'b00, 0, 0));
        cyc_b("nw_mem", v_sw_mem);
        cyc_b("nw_if2", v_if);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
